modbus_resp_ctrl: RTL and testbench
===================================

Name: modbus_resp_ctrl

Overview:
- Response sequencer of the Modbus RTU slave. Runs after the request exception checker.
- On the checker's one-cycle `exception_done` strobe it captures the verdict and request fields, then builds the reply frame byte by byte: exception reply, read reply (0x03/0x04) or write echo (0x06).
- Issues the register-file read/write accesses for the reply, runs a CRC-16/Modbus over the outgoing bytes, and hands each byte to the UART transmitter using a start/busy handshake.

Parameters:
- MAX_REGS, 4, maximum registers in a read reply; sets the register-index counter width.
- TX_TIMEOUT, 1023, clock cycles allowed for `tx_busy` to assert after `tx_start` before the frame is aborted.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous active-low reset.
- exception_done  input  1  one-cycle strobe: verdict valid.
- exception  input  8  0x00 = OK, otherwise Modbus exception code.
- slave_id  input  8  own station address, echoed as byte 0.
- func_code  input  8  request function code.
- addr  input  16  request start/register address.
- data  input  16  request quantity (0x03/0x04) or write value (0x06).
- reg_rd_en  output  1  register read strobe.
- reg_rd_addr  output  16  register read address.
- reg_rd_data  input  16  read data, valid the cycle after `reg_rd_en`.
- reg_wr_en  output  1  register write strobe (function 0x06).
- reg_wr_addr  output  16  register write address.
- reg_wr_data  output  16  register write data.
- tx_start  output  1  one-cycle start pulse to the UART transmitter.
- tx_data  output  8  byte to transmit, stable while `tx_start` is high.
- tx_busy  input  1  UART transmitter busy.
- resp_busy  output  1  high from capture until done or abort.
- resp_done  output  1  one-cycle pulse when the last CRC byte has finished sending.
- resp_abort  output  1  one-cycle pulse when a TX timeout kills the frame.
- resp_overrun  output  1  one-cycle pulse when `exception_done` arrives while `resp_busy` is high.

Behaviour:
- Reset: every output is 0, state is IDLE, CRC register is 0xFFFF.
- Capture: in IDLE, `exception_done` latches all inputs. `resp_busy` is 1 from the next cycle.
- `exception_done` while busy: inputs ignored, `resp_overrun` pulses, the frame in progress is unaffected.
- Frame contents:
  - exception≠0: id, func|0x80, exception, crc_lo, crc_hi.
  - 0x03/0x04: id, func, 2·N (8 bits), then N registers high byte first (N = `data[7:0]`, clamped to MAX_REGS), then crc_lo, crc_hi.
  - 0x06: id, 06, addr_hi, addr_lo, data_hi, data_lo, crc_lo, crc_hi.
- Write side effect (0x06 with exception=0): `reg_wr_en` pulses exactly once, in the cycle after capture, with the latched addr and data. No write occurs for any exception frame.
- Register reads: for register i, `reg_rd_en` pulses with `reg_rd_addr` = addr + i (16-bit wrap). The data is captured the next cycle, before the high byte is sent.
- States:
  - IDLE → LOAD (select the next byte; issue a read if needed) → RD_WAIT (reads only) → SEND.
  - SEND: waits for `tx_busy`=0 and CRC unit idle, then pulses `tx_start` → WAIT_ACK.
  - WAIT_ACK: waits for `tx_busy`=1 → WAIT_IDLE.
  - WAIT_IDLE: on `tx_busy`=0, go to LOAD, or to DONE after crc_hi.
  - DONE: pulses `resp_done` → IDLE.
- CRC:
  - Poly 0xA001 (reflected), init 0xFFFF.
  - Each payload byte is fed to the CRC unit at its `tx_start`; the unit is bit-serial, 8 cycles per byte.
  - crc_lo/crc_hi are not fed to the CRC unit. They are sent from the CRC register, which is frozen once the last payload byte completes.
  - CRC is reset to 0xFFFF on each capture.
- Timeout: a counter runs in WAIT_ACK. When it reaches TX_TIMEOUT: `resp_abort` pulses, `tx_start` is held low, state → IDLE. `resp_done` is not asserted.
- Reset mid-frame: immediate return to IDLE with all outputs 0. No partial-byte recovery.
- Byte counter: 4 bits for a maximum frame of 5+2·MAX_REGS bytes.

Decomposition:
- Shared package `modbus_pkg`:
  - function codes: FC_RD_HOLD = 0x03, FC_RD_IN = 0x04, FC_WR_SINGLE = 0x06;
  - exception-flag bit 0x80;
  - CRC_INIT = 0xFFFF, CRC_POLY = 0xA001;
  - state encoding.
- Sub-module `crc16_modbus_ser`: 8-cycle bit-serial CRC with init, byte_en, byte_in, busy and crc outputs. It is reused by the RX path.

Test Plan:
- Exception path: exception=0x02, func=0x03, slave_id=0x01 → TX bytes 01 83 02 C0 F1. No `reg_rd_en` or `reg_wr_en`. One `resp_done`.
- Read reply: func=0x03, addr=0x0001, data=0x0002, registers [1]=0x1234, [2]=0xABCD → 01 03 04 12 34 AB CD + CRC matching the golden model. `reg_rd_addr` sequence is 0x0001, 0x0002.
- Write echo: func=0x06, addr=0x0001, data=0x0010 → single `reg_wr_en` (0x0001, 0x0010). TX 01 06 00 01 00 10 + CRC.
- Handshake: `tx_busy` asserted 3 cycles after each `tx_start`, held for 50 cycles → exactly one `tx_start` per byte, never while `tx_busy`=1.
- Timeout: `tx_busy` stuck low → `resp_abort` after TX_TIMEOUT cycles. `resp_busy` drops. The next `exception_done` produces a full, correct frame.
- Overrun and reset: second `exception_done` mid-frame → `resp_overrun` pulse and the first frame is unaltered. `rst_n_in` low mid-frame → all outputs 0 asynchronously.

Source files
------------

// File: rtl/modbus_pkg.sv
// -----------------------------------------------------------------------------
// modbus_pkg
// Shared definitions for the Modbus RTU slave: function codes, exception flag,
// CRC-16/Modbus constants, response-sequencer state encoding and the latched
// request record used by the response controller.
// No ports (package).
// -----------------------------------------------------------------------------
package modbus_pkg;

  // Function codes handled by the slave
  localparam logic [7:0] FC_RD_HOLD   = 8'h03;
  localparam logic [7:0] FC_RD_IN     = 8'h04;
  localparam logic [7:0] FC_WR_SINGLE = 8'h06;

  // Set in the echoed function code of an exception reply
  localparam logic [7:0] EXC_FLAG = 8'h80;

  // Exception code used if a function slips past the checker unflagged
  localparam logic [7:0] EXC_ILLEGAL_FUNC = 8'h01;

  // CRC-16/Modbus: reflected polynomial, all-ones seed
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RD_WAIT,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_IDLE,
    ST_DONE
  } resp_state_e;

  typedef enum logic [1:0] {
    FK_EXC,
    FK_READ,
    FK_WRITE
  } frame_kind_e;

  // Request fields frozen at capture time
  typedef struct packed {
    frame_kind_e kind;
    logic [7:0]  exc;
    logic [7:0]  id;
    logic [7:0]  func;
    logic [15:0] addr;
    logic [15:0] data;
    logic [7:0]  n_regs;   // register count after clamping
  } resp_req_t;

  // Which reply layout a verdict/function pair produces. Any function the
  // sequencer cannot build a normal reply for is answered as an exception.
  function automatic frame_kind_e classify(input logic [7:0] exc,
                                           input logic [7:0] func);
    frame_kind_e kind;
    kind = FK_EXC;
    if (exc == 8'h00) begin
      case (func)
        FC_RD_HOLD, FC_RD_IN: kind = FK_READ;
        FC_WR_SINGLE:         kind = FK_WRITE;
        default:              kind = FK_EXC;
      endcase
    end
    return kind;
  endfunction

endpackage

// File: rtl/crc16_modbus_ser.sv
// -----------------------------------------------------------------------------
// crc16_modbus_ser
// Bit-serial CRC-16/Modbus engine, one data bit per clock, 8 clocks per byte.
// Shared by the TX response path and the RX request path.
//
// Ports:
//   clk_in    in   system clock
//   rst_n_in  in   asynchronous active-low reset (crc -> CRC_INIT)
//   init      in   reseed crc to CRC_INIT, cancels a byte in progress
//   byte_en   in   start folding byte_in into the crc (ignored while init)
//   byte_in   in   [7:0] byte to fold in, sampled with byte_en
//   busy      out  high during the 8 clocks a byte is being folded in
//   crc       out  [15:0] current remainder, stable whenever busy is low
// -----------------------------------------------------------------------------
module crc16_modbus_ser
  import modbus_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        init,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        busy,
  output logic [15:0] crc
);

  logic [7:0] shift_q;
  logic [3:0] bit_cnt_q;
  logic       feedback;

  // Reflected CRC: the LSB of data and remainder leave first
  assign feedback = crc[0] ^ shift_q[0];
  assign busy     = (bit_cnt_q != 4'd0);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      crc       <= CRC_INIT;
      shift_q   <= 8'h00;
      bit_cnt_q <= 4'd0;
    end else if (init) begin
      crc       <= CRC_INIT;
      bit_cnt_q <= 4'd0;
    end else if (byte_en) begin
      shift_q   <= byte_in;
      bit_cnt_q <= 4'd8;
    end else if (busy) begin
      crc       <= (crc >> 1) ^ (feedback ? CRC_POLY : 16'h0000);
      shift_q   <= shift_q >> 1;
      bit_cnt_q <= bit_cnt_q - 4'd1;
    end
  end

endmodule

// File: rtl/modbus_resp_ctrl.sv
// -----------------------------------------------------------------------------
// modbus_resp_ctrl
// Modbus RTU slave response sequencer. On the exception checker's verdict
// strobe it freezes the request, then emits the reply frame one byte at a
// time to the UART transmitter: exception reply, read reply (0x03/0x04) or
// write echo (0x06), each closed by CRC-16/Modbus (low byte first).
//
// Parameters:
//   MAX_REGS    registers per read reply (frame must fit the 4-bit byte
//               counter, so at most 5)
//   TX_TIMEOUT  cycles after tx_start within which tx_busy must rise
//
// Ports:
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   exception_done          in   verdict strobe (one cycle)
//   exception [7:0]         in   0 = OK, else exception code
//   slave_id  [7:0]         in   own address, byte 0 of every reply
//   func_code [7:0]         in   request function code
//   addr      [15:0]        in   start / register address
//   data      [15:0]        in   quantity (read) or value (write)
//   reg_rd_en/reg_rd_addr   out  register read strobe and address
//   reg_rd_data [15:0]      in   read data, valid the cycle after the strobe
//   reg_wr_en/addr/data     out  single register write (0x06)
//   tx_start, tx_data [7:0] out  byte hand-off pulse and byte
//   tx_busy                 in   transmitter busy
//   resp_busy               out  reply in progress
//   resp_done               out  pulse after the last CRC byte went out
//   resp_abort              out  pulse when the transmitter never responded
//   resp_overrun            out  pulse when a verdict arrives while busy
// -----------------------------------------------------------------------------
module modbus_resp_ctrl
  import modbus_pkg::*;
#(
  parameter int MAX_REGS   = 4,
  parameter int TX_TIMEOUT = 1023
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        exception_done,
  input  logic [7:0]  exception,
  input  logic [7:0]  slave_id,
  input  logic [7:0]  func_code,
  input  logic [15:0] addr,
  input  logic [15:0] data,
  output logic        reg_rd_en,
  output logic [15:0] reg_rd_addr,
  input  logic [15:0] reg_rd_data,
  output logic        reg_wr_en,
  output logic [15:0] reg_wr_addr,
  output logic [15:0] reg_wr_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        resp_busy,
  output logic        resp_done,
  output logic        resp_abort,
  output logic        resp_overrun
);

  localparam int         REG_IDX_W  = (MAX_REGS > 1) ? $clog2(MAX_REGS) : 1;
  localparam int         TO_W       = $clog2(TX_TIMEOUT + 1);
  localparam logic [7:0] MAX_REGS_B = 8'(MAX_REGS);

  resp_state_e    state_q, state_d;
  resp_req_t      req_q, req_d;
  logic [3:0]     byte_idx_q;     // index of the byte being sent
  logic [3:0]     frame_len_q;    // total bytes including the two CRC bytes
  logic [3:0]     frame_len_d;
  logic [15:0]    rd_data_q;      // register value feeding the next two bytes
  logic [TO_W-1:0] to_cnt_q;      // cycles since tx_start while awaiting busy

  logic           capture;
  logic           is_payload, is_crc_lo, is_crc_hi;
  logic           is_reg_byte, reg_byte_hi;
  logic [3:0]     reg_off;
  logic [REG_IDX_W-1:0] reg_idx;

  logic           crc_busy;
  logic [15:0]    crc_val;

  // ---------------------------------------------------------------------------
  // Capture decode
  // ---------------------------------------------------------------------------
  assign capture = (state_q == ST_IDLE) && exception_done;

  always_comb begin
    req_d.kind   = classify(exception, func_code);
    req_d.id     = slave_id;
    req_d.func   = func_code;
    req_d.addr   = addr;
    req_d.data   = data;
    req_d.n_regs = (data[7:0] > MAX_REGS_B) ? MAX_REGS_B : data[7:0];
    req_d.exc    = exception;
    if (req_d.kind == FK_EXC && exception == 8'h00) begin
      req_d.exc = EXC_ILLEGAL_FUNC;
    end
    case (req_d.kind)
      FK_READ:  frame_len_d = 4'(8'd5 + (req_d.n_regs << 1));
      FK_WRITE: frame_len_d = 4'd8;
      default:  frame_len_d = 4'd5;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Byte position decode
  // ---------------------------------------------------------------------------
  assign is_crc_lo  = (byte_idx_q == frame_len_q - 4'd2);
  assign is_crc_hi  = (byte_idx_q == frame_len_q - 4'd1);
  assign is_payload = (byte_idx_q <  frame_len_q - 4'd2);

  // Register bytes start at index 3, high byte on even offsets
  assign reg_off     = byte_idx_q - 4'd3;
  assign reg_idx     = REG_IDX_W'(reg_off >> 1);
  assign reg_byte_hi = ~reg_off[0];
  assign is_reg_byte = (req_q.kind == FK_READ) && (byte_idx_q >= 4'd3) && is_payload;

  assign reg_rd_addr = reg_rd_en ? (req_q.addr + 16'(reg_idx)) : 16'h0000;
  assign reg_wr_addr = req_q.addr;
  assign reg_wr_data = req_q.data;

  assign resp_busy    = (state_q != ST_IDLE);
  assign resp_overrun = exception_done && resp_busy;

  // The CRC bytes come straight from the CRC register, which stops moving
  // once the last payload byte has been folded in.
  always_comb begin
    tx_data = 8'h00;
    if (is_crc_lo) begin
      tx_data = crc_val[7:0];
    end else if (is_crc_hi) begin
      tx_data = crc_val[15:8];
    end else begin
      case (req_q.kind)
        FK_READ: begin
          case (byte_idx_q)
            4'd0:    tx_data = req_q.id;
            4'd1:    tx_data = req_q.func;
            4'd2:    tx_data = 8'(req_q.n_regs << 1);
            default: tx_data = reg_byte_hi ? rd_data_q[15:8] : rd_data_q[7:0];
          endcase
        end
        FK_WRITE: begin
          case (byte_idx_q)
            4'd0:    tx_data = req_q.id;
            4'd1:    tx_data = req_q.func;
            4'd2:    tx_data = req_q.addr[15:8];
            4'd3:    tx_data = req_q.addr[7:0];
            4'd4:    tx_data = req_q.data[15:8];
            default: tx_data = req_q.data[7:0];
          endcase
        end
        default: begin
          case (byte_idx_q)
            4'd0:    tx_data = req_q.id;
            4'd1:    tx_data = req_q.func | EXC_FLAG;
            default: tx_data = req_q.exc;
          endcase
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer: next state and strobes
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a value held and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    reg_rd_en  = 1'b0;
    reg_wr_en  = 1'b0;
    tx_start   = 1'b0;
    resp_done  = 1'b0;
    resp_abort = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (exception_done) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // Byte 0's LOAD is the cycle right after capture: the write slot
        if (req_q.kind == FK_WRITE && byte_idx_q == 4'd0) reg_wr_en = 1'b1;
        if (is_reg_byte && reg_byte_hi) begin
          reg_rd_en = 1'b1;
          state_d   = ST_RD_WAIT;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_RD_WAIT: begin
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_busy && !crc_busy) begin
          tx_start = 1'b1;
          state_d  = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (tx_busy) begin
          state_d = ST_WAIT_IDLE;
        end else if (to_cnt_q == TO_W'(TX_TIMEOUT)) begin
          resp_abort = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (!tx_busy) state_d = is_crc_hi ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        resp_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the request record is reset although it is only meaningful after a
  // capture; the outputs decoded from it must read 0 while in reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      frame_len_q <= 4'd0;
      byte_idx_q  <= 4'd0;
      rd_data_q   <= 16'h0000;
      to_cnt_q    <= '0;
    end else begin
      state_q <= state_d;

      if (capture) begin
        req_q       <= req_d;
        frame_len_q <= frame_len_d;
        byte_idx_q  <= 4'd0;
      end else if (state_q == ST_WAIT_IDLE && !tx_busy && !is_crc_hi) begin
        byte_idx_q <= byte_idx_q + 4'd1;
      end

      if (state_q == ST_RD_WAIT) rd_data_q <= reg_rd_data;

      if (tx_start) begin
        to_cnt_q <= TO_W'(1);
      end else if (state_q == ST_WAIT_ACK) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
    end
  end

  // Only payload bytes are folded into the CRC; it is reseeded per frame
  crc16_modbus_ser u_crc (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .init     (capture),
    .byte_en  (tx_start && is_payload),
    .byte_in  (tx_data),
    .busy     (crc_busy),
    .crc      (crc_val)
  );

endmodule

// File: tb/tb_modbus_resp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_modbus_resp_ctrl
// Self-checking bench for modbus_resp_ctrl: a UART/register-file responder
// model, a frame-level reference model, directed and randomized frames.
// -----------------------------------------------------------------------------
module tb_modbus_resp_ctrl;

  localparam int MAX_REGS   = 4;
  localparam int TX_TIMEOUT = 1023;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        exception_done = 1'b0;
  logic [7:0]  exception = 8'h00;
  logic [7:0]  slave_id = 8'h00;
  logic [7:0]  func_code = 8'h00;
  logic [15:0] addr = 16'h0000;
  logic [15:0] data = 16'h0000;
  logic        reg_rd_en;
  logic [15:0] reg_rd_addr;
  logic [15:0] reg_rd_data = 16'h0000;
  logic        reg_wr_en;
  logic [15:0] reg_wr_addr;
  logic [15:0] reg_wr_data;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        resp_busy, resp_done, resp_abort, resp_overrun;

  modbus_resp_ctrl #(.MAX_REGS(MAX_REGS), .TX_TIMEOUT(TX_TIMEOUT)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .exception_done(exception_done),
    .exception(exception), .slave_id(slave_id), .func_code(func_code),
    .addr(addr), .data(data), .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr),
    .reg_rd_data(reg_rd_data), .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .resp_busy(resp_busy), .resp_done(resp_done),
    .resp_abort(resp_abort), .resp_overrun(resp_overrun)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Register file contents and responder observations
  logic [15:0] mem [256];
  logic [7:0]  tx_log [$];
  logic [15:0] rd_log [$];
  logic [31:0] wr_log [$];
  int cyc = 0, wr_cyc = -1, cap_cyc = -1, start_cyc = 0, abort_cyc = 0;
  int done_cnt = 0, abort_cnt = 0, ovr_cnt = 0, hs_bad = 0;
  int busy_delay = 3, busy_hold = 50;
  bit stuck = 1'b0;

  // Reference expectations
  logic [7:0]  exp_q [$];
  logic [15:0] exp_rd [$];
  bit          exp_wr;

  // Responder: sampled and driven on the falling edge, away from the DUT edge
  initial begin : responder
    int dly, hold;
    bit pend;
    logic [15:0] pend_a;
    dly = 0; hold = 0; pend = 1'b0; pend_a = 16'h0;
    forever begin
      @(negedge clk_in);
      cyc++;
      if (!rst_n_in) begin
        tx_busy = 1'b0; dly = 0; hold = 0; pend = 1'b0;
      end else begin
        // Read data is only meaningful in the cycle after the strobe
        reg_rd_data = pend ? mem[pend_a[7:0]] : 16'($urandom);
        pend   = reg_rd_en;
        pend_a = reg_rd_addr;
        if (reg_rd_en) rd_log.push_back(reg_rd_addr);
        if (reg_wr_en) begin wr_log.push_back({reg_wr_addr, reg_wr_data}); wr_cyc = cyc; end
        if (resp_done) done_cnt++;
        if (resp_abort) begin abort_cnt++; abort_cyc = cyc; end
        if (resp_overrun) ovr_cnt++;
        if (exception_done && !resp_busy) cap_cyc = cyc;
        if (tx_start) begin
          if (tx_busy) hs_bad++;
          tx_log.push_back(tx_data);
          start_cyc = cyc;
          if (!stuck) dly = busy_delay;
        end else if (dly > 0) begin
          dly--;
          if (dly == 0) begin tx_busy = 1'b1; hold = busy_hold; end
        end else if (tx_busy) begin
          hold--;
          if (hold == 0) tx_busy = 1'b0;
        end
      end
    end
  end

  // Frame-level reference: reply layout and CRC-16/Modbus, byte at a time
  task automatic build_expected(input logic [7:0] exc, id, fc, input logic [15:0] a, d);
    logic [15:0] crc, ra, v;
    int n;
    exp_q.delete(); exp_rd.delete(); exp_wr = 1'b0;
    exp_q.push_back(id);
    if (exc != 8'h00) begin
      exp_q.push_back(fc | 8'h80);
      exp_q.push_back(exc);
    end else if (fc == 8'h03 || fc == 8'h04) begin
      n = (int'(d[7:0]) > MAX_REGS) ? MAX_REGS : int'(d[7:0]);
      exp_q.push_back(fc);
      exp_q.push_back(8'(2 * n));
      for (int i = 0; i < n; i++) begin
        ra = a + 16'(i);
        v  = mem[ra[7:0]];
        exp_rd.push_back(ra);
        exp_q.push_back(v[15:8]);
        exp_q.push_back(v[7:0]);
      end
    end else begin
      exp_q.push_back(fc);
      exp_q.push_back(a[15:8]); exp_q.push_back(a[7:0]);
      exp_q.push_back(d[15:8]); exp_q.push_back(d[7:0]);
      exp_wr = 1'b1;
    end
    crc = 16'hFFFF;
    foreach (exp_q[i]) begin
      crc = crc ^ {8'h00, exp_q[i]};
      for (int b = 0; b < 8; b++) crc = crc[0] ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
    end
    exp_q.push_back(crc[7:0]);
    exp_q.push_back(crc[15:8]);
  endtask

  task automatic scramble_inputs();
    exception = 8'($urandom); slave_id = 8'($urandom); func_code = 8'($urandom);
    addr = 16'($urandom); data = 16'($urandom);
  endtask

  task automatic drive_request(input logic [7:0] exc, id, fc, input logic [15:0] a, d);
    @(posedge clk_in); #1;
    exception = exc; slave_id = id; func_code = fc; addr = a; data = d;
    exception_done = 1'b1;
    @(posedge clk_in); #1;
    exception_done = 1'b0;
    scramble_inputs();
  endtask

  // One full reply, compared against the reference; optional overrun strobe
  task automatic run_frame(input logic [7:0] exc, id, fc, input logic [15:0] a, d,
                           input bit inject);
    int d0, a0, o0, h0, k;
    build_expected(exc, id, fc, a, d);
    tx_log.delete(); rd_log.delete(); wr_log.delete();
    d0 = done_cnt; a0 = abort_cnt; o0 = ovr_cnt; h0 = hs_bad;
    drive_request(exc, id, fc, a, d);
    check("busy_rise", resp_busy, 1);
    k = 0;
    while (done_cnt == d0 && abort_cnt == a0 && k < 4000) begin
      @(posedge clk_in); #1;
      k++;
      if (inject && k == 20) begin
        scramble_inputs();
        exception_done = 1'b1;
      end else begin
        exception_done = 1'b0;
      end
    end
    exception_done = 1'b0;
    check("frame_end", (k < 4000), 1);
    check("done_cnt", done_cnt - d0, 1);
    check("abort_cnt", abort_cnt - a0, 0);
    check("overrun_cnt", ovr_cnt - o0, inject ? 1 : 0);
    check("handshake", hs_bad - h0, 0);
    check("n_bytes", tx_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
      check($sformatf("byte%0d", i), tx_log[i], exp_q[i]);
    check("n_reads", rd_log.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
      check($sformatf("rd_addr%0d", i), rd_log[i], exp_rd[i]);
    check("n_writes", wr_log.size(), exp_wr ? 1 : 0);
    if (exp_wr && wr_log.size() > 0) begin
      check("wr_val", wr_log[0], {a, d});
      check("wr_cycle", wr_cyc, cap_cyc + 1);
    end
    @(posedge clk_in); #1;
    check("busy_fall", resp_busy, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_strobes"}, {reg_rd_en, reg_wr_en, tx_start, resp_busy,
                              resp_done, resp_abort, resp_overrun}, 0);
    check({tag, "_addrs"}, {reg_rd_addr, reg_wr_addr}, 0);
    check({tag, "_data"}, {reg_wr_data, tx_data}, 0);
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [7:0] lit [5];
    int a0, d0, k, lat;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[1] = 16'h1234;
    mem[2] = 16'hABCD;

    // Reset state
    repeat (3) @(posedge clk_in);
    #1;
    check_outputs_zero("reset");
    rst_n_in = 1'b1;
    repeat (2) @(posedge clk_in);

    // Exception reply with known CRC; busy rises 3 cycles after start, 50 long
    busy_delay = 3; busy_hold = 50;
    run_frame(8'h02, 8'h01, 8'h03, 16'h0001, 16'h0002, 1'b0);
    lit[0] = 8'h01; lit[1] = 8'h83; lit[2] = 8'h02; lit[3] = 8'hC0; lit[4] = 8'hF1;
    for (int i = 0; i < 5 && i < tx_log.size(); i++)
      check($sformatf("exc_lit%0d", i), tx_log[i], lit[i]);

    // Read reply and write echo
    run_frame(8'h00, 8'h01, 8'h03, 16'h0001, 16'h0002, 1'b0);
    if (tx_log.size() > 6) check("rd_lit", {tx_log[3], tx_log[4], tx_log[5], tx_log[6]}, 32'h1234ABCD);
    run_frame(8'h00, 8'h01, 8'h06, 16'h0001, 16'h0010, 1'b0);

    // Boundaries: address wrap, quantity clamp, zero quantity
    run_frame(8'h00, 8'h11, 8'h04, 16'hFFFE, 16'h0003, 1'b0);
    run_frame(8'h00, 8'h22, 8'h03, 16'h0040, 16'h0009, 1'b0);
    run_frame(8'h00, 8'h33, 8'h04, 16'h0080, 16'h0000, 1'b0);

    // Overrun: second verdict mid-frame must leave the reply untouched
    run_frame(8'h00, 8'h05, 8'h03, 16'h0010, 16'h0003, 1'b1);

    // Timeout: transmitter never goes busy
    stuck = 1'b1;
    tx_log.delete();
    a0 = abort_cnt; d0 = done_cnt;
    drive_request(8'h00, 8'h01, 8'h03, 16'h0001, 16'h0002);
    k = 0;
    while (abort_cnt == a0 && k < 3000) begin @(posedge clk_in); #1; k++; end
    check("abort_seen", abort_cnt - a0, 1);
    lat = abort_cyc - start_cyc;
    check("abort_latency", (lat >= TX_TIMEOUT && lat <= TX_TIMEOUT + 1), 1);
    check("abort_bytes", tx_log.size(), 1);
    check("abort_no_done", done_cnt - d0, 0);
    @(posedge clk_in); #1;
    check("abort_busy", resp_busy, 0);
    stuck = 1'b0;
    run_frame(8'h00, 8'h01, 8'h03, 16'h0001, 16'h0002, 1'b0);

    // Asynchronous reset in the middle of a frame
    drive_request(8'h00, 8'h07, 8'h06, 16'h1234, 16'h5678);
    repeat (30) @(posedge clk_in);
    #1;
    check("pre_reset_busy", resp_busy, 1);
    @(negedge clk_in); #2;
    rst_n_in = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    repeat (3) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    repeat (2) @(posedge clk_in);
    run_frame(8'h00, 8'h07, 8'h06, 16'h1234, 16'h5678, 1'b0);

    // Randomized frames and transmitter timing
    for (int n = 0; n < 20; n++) begin
      logic [7:0] id, fc, ex;
      logic [15:0] a, d;
      int kind;
      busy_delay = $urandom_range(1, 5);
      busy_hold  = $urandom_range(1, 20);
      kind = $urandom_range(0, 3);
      id = 8'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
      d  = 16'($urandom);
      ex = 8'h00;
      case (kind)
        0: begin ex = 8'($urandom_range(1, 4)); fc = 8'($urandom_range(1, 127)); end
        1: begin fc = 8'h03; d[7:0] = 8'($urandom_range(0, 7)); end
        2: begin fc = 8'h04; d[7:0] = 8'($urandom_range(0, 7)); end
        default: fc = 8'h06;
      endcase
      run_frame(ex, id, fc, a, d, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
